hash_function_mb: RTL and testbench
===================================

Name: hash_function_mb

Overview:
- Parametrised multi-block successor of the single-block `hash_function`.
- Absorbs a message of one or more NBYTES-wide blocks through a valid/ready stream and chains them Davies-Meyer style from a caller-supplied IV.
- Produces an NBYTES-byte digest with a one-cycle `done` pulse.
- Sits between the message-buffer logic and the digest consumer; one round per clock.

Parameters:
- NBYTES, 4, bytes per block, IV and digest (2..16)
- ROUNDS, 8, compression rounds per block (1..255)
- CNT_W, 8, width of the absorbed-block counter

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset, sampled on rising clk
- start  in  1  begin new message: load chaining state from IV
- IV  in  8 x [0:NBYTES-1]  initial chaining value, sampled on accepted start
- blk_data  in  8 x [0:NBYTES-1]  message block m
- blk_valid  in  1  blk_data/blk_last valid
- blk_last  in  1  marks final block of message
- blk_ready  out  1  block can be accepted
- d  out  8 x [0:NBYTES-1]  digest, held until next digest or reset
- done  out  1  single-cycle pulse: d updated
- busy  out  1  high in every state except IDLE
- blk_count  out  CNT_W  blocks absorbed in current message, saturating

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; d=all 0x00; done=0; blk_ready=0; busy=0; blk_count=0; internal h, m, round counter cleared.
  - Reset mid-operation aborts the message with no done pulse.
- FSM states:
  - IDLE: start=1 -> h<=IV, blk_count<=0, go WAIT_BLK.
  - WAIT_BLK:
    - blk_ready=1 (combinational from state only).
    - blk_valid&&blk_ready -> m<=blk_data, hs<=h (feed-forward copy), last_q<=blk_last, r<=0, go ROUND.
  - ROUND:
    - Each cycle applies round r and increments r.
    - At r==ROUNDS-1 the edge writes h<=round_out ^ hs and increments blk_count, saturating at 2^CNT_W-1.
    - Then: last_q=1 -> d<=that value, done<=1, go IDLE; otherwise go WAIT_BLK.
- Round function, all arithmetic mod 256, indices mod NBYTES:
  - t[i] = h[i] ^ m[(i+r) mod NBYTES]
  - h'[i] = rotl8(t[i] + t[(i+1) mod NBYTES], 3) ^ r[7:0]
  - All bytes are updated in parallel from the pre-round h.
- Latency:
  - done is high in the cycle following the ROUNDS-th edge after the final block's acceptance edge.
  - Throughput is one block per ROUNDS+1 cycles.
- done is a pulse: deasserted one cycle later.
- start:
  - start is ignored while busy=1.
  - start and blk_valid in the same IDLE cycle: only start is acted on, and no block is accepted.
- blk_valid outside WAIT_BLK has no effect; the source must hold data until accepted.
- d is not modified by non-last blocks.
- d retains the previous digest through subsequent messages until their completion.
- blk_count is held after done until the next accepted start.

Test Plan:
- ROUNDS=4, NBYTES=4; IV=00 00 00 00; start; one block 00 00 00 00 with last=1 -> d=22 22 22 22. done pulses exactly 1 cycle, 4 edges after acceptance. blk_count=1, busy low after done.
- ROUNDS=4; IV=0; two zero blocks, second with last=1:
  - No done pulse after block 1, and d still 0.
  - Chaining value after block 1 is 22 22 22 22.
  - Final d=22 22 22 22; blk_count=2.
- Handshake: hold blk_valid=1 with blk_data=01 02 03 04 from the cycle after start.
  - blk_ready is high only in WAIT_BLK cycles.
  - Exactly one acceptance per block.
  - Changing blk_data during ROUND leaves d unchanged versus a reference model.
- Assert start during ROUND with IV=BB AA 99 88 -> ignored; digest equals the model result for the original IV 34 55 0F 14.
- rst_n=0 for one cycle mid-ROUND -> next cycle d=0, done=0, busy=0, blk_ready=0. A fresh message then completes with the correct model digest.
- CNT_W=2, six-block message -> blk_count reads 1,2,3,3,3,3; digest matches the model.

Source files
------------

// File: rtl/hash_function_mb_if.sv
// Block stream, IV/start control and digest/status bundle for hash_function_mb.
// Byte 0 of every NBYTES-wide vector is the most significant byte.
interface hash_function_mb_if #(
    parameter int NBYTES = 4,
    parameter int CNT_W  = 8
);
    logic                   start;
    logic [0:NBYTES-1][7:0] IV;
    logic [0:NBYTES-1][7:0] blk_data;
    logic                   blk_valid;
    logic                   blk_last;
    logic                   blk_ready;
    logic [0:NBYTES-1][7:0] d;
    logic                   done;
    logic                   busy;
    logic [CNT_W-1:0]       blk_count;

    modport master (
        output start, IV, blk_data, blk_valid, blk_last,
        input  blk_ready, d, done, busy, blk_count
    );

    modport slave (
        input  start, IV, blk_data, blk_valid, blk_last,
        output blk_ready, d, done, busy, blk_count
    );
endinterface

// File: rtl/hash_function_mb.sv
// Multi-block Davies-Meyer hash, one round per clk; done pulses the cycle after the final block's ROUNDS-th round.
// Backpressure: blk_ready is high only while waiting for a block; the source holds the block until accepted.
module hash_function_mb #(
    parameter int NBYTES = 4,
    parameter int ROUNDS = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    hash_function_mb_if.slave bus
);
    typedef logic [0:NBYTES-1][7:0] blk_t;
    typedef enum logic [1:0] {IDLE, WAIT_BLK, ROUND} state_t;

    localparam logic [7:0] LAST_R = 8'(ROUNDS - 1);

    state_t           state;
    blk_t             h;
    blk_t             hs;
    blk_t             m;
    blk_t             d_q;
    blk_t             round_out;
    blk_t             m_next;
    logic [7:0]       r;
    logic             last_q;
    logic             done_q;
    logic [CNT_W-1:0] cnt_q;

    // m is rotated one byte left every round, so m[i] always holds original m[(i+r) mod NBYTES]
    for (genvar i = 0; i < NBYTES; i++) begin : g_byte
        localparam int J = (i + 1) % NBYTES;
        logic [7:0] t_i;
        logic [7:0] t_j;
        logic [7:0] sum;
        assign t_i          = h[i] ^ m[i];
        assign t_j          = h[J] ^ m[J];
        assign sum          = t_i + t_j;
        assign round_out[i] = {sum[4:0], sum[7:5]} ^ r;
        assign m_next[i]    = m[J];
    end

    assign bus.blk_ready = (state == WAIT_BLK);
    assign bus.busy      = (state != IDLE);
    assign bus.d         = d_q;
    assign bus.done      = done_q;
    assign bus.blk_count = cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            h      <= '0;
            hs     <= '0;
            m      <= '0;
            d_q    <= '0;
            r      <= '0;
            last_q <= 1'b0;
            done_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        h     <= bus.IV;
                        cnt_q <= '0;
                        state <= WAIT_BLK;
                    end
                end
                WAIT_BLK: begin
                    if (bus.blk_valid) begin
                        m      <= bus.blk_data;
                        hs     <= h;
                        last_q <= bus.blk_last;
                        r      <= '0;
                        state  <= ROUND;
                    end
                end
                ROUND: begin
                    m <= m_next;
                    r <= r + 8'd1;
                    if (r == LAST_R) begin
                        h <= round_out ^ hs;
                        if (cnt_q != {CNT_W{1'b1}}) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                        if (last_q) begin
                            d_q    <= round_out ^ hs;
                            done_q <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            state <= WAIT_BLK;
                        end
                    end else begin
                        h <= round_out;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_hash_function_mb.sv
// Directed bench for hash_function_mb: vector table for single-block digests plus
// hand-written sequences for chaining, handshake, ignored start, reset abort and counter saturation.
module tb_hash_function_mb;
    localparam int NB  = 4;
    localparam int RND = 4;

    typedef logic [0:NB-1][7:0] blk_t;
    typedef struct {
        blk_t iv;
        blk_t blk;
        blk_t exp;
    } vec_t;

    logic clk;
    logic rst_n;
    logic start;
    logic blk_valid;
    logic blk_last;
    blk_t iv;
    blk_t blk_data;

    int checks = 0;
    int errors = 0;

    hash_function_mb_if #(.NBYTES(NB), .CNT_W(8)) ifa ();
    hash_function_mb_if #(.NBYTES(NB), .CNT_W(2)) ifb ();

    assign ifa.start     = start;
    assign ifa.IV        = iv;
    assign ifa.blk_data  = blk_data;
    assign ifa.blk_valid = blk_valid;
    assign ifa.blk_last  = blk_last;
    assign ifb.start     = start;
    assign ifb.IV        = iv;
    assign ifb.blk_data  = blk_data;
    assign ifb.blk_valid = blk_valid;
    assign ifb.blk_last  = blk_last;

    hash_function_mb #(.NBYTES(NB), .ROUNDS(RND), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    hash_function_mb #(.NBYTES(NB), .ROUNDS(RND), .CNT_W(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic blk_t model_blk(input blk_t h_in, input blk_t m);
        blk_t h;
        blk_t t;
        blk_t n;
        logic [7:0] s;
        h = h_in;
        for (int r = 0; r < RND; r++) begin
            for (int i = 0; i < NB; i++) t[i] = h[i] ^ m[(i + r) % NB];
            for (int i = 0; i < NB; i++) begin
                s    = t[i] + t[(i + 1) % NB];
                n[i] = ((s << 3) | (s >> 5)) ^ 8'(r);
            end
            h = n;
        end
        return h ^ h_in;
    endfunction

    function automatic blk_t model_msg(input blk_t v, input blk_t q[$]);
        blk_t h;
        h = v;
        foreach (q[k]) h = model_blk(h, q[k]);
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic do_start(input blk_t v);
        @(negedge clk);
        start = 1'b1;
        iv    = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents one block, waits for its acceptance, then steps through its rounds.
    task automatic absorb(input blk_t b, input logic last, output int first_done);
        int n;
        blk_data  = b;
        blk_last  = last;
        blk_valid = 1'b1;
        n = 0;
        while (!ifa.blk_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("blk_ready_seen", ifa.blk_ready, 1);
        @(negedge clk);
        blk_valid  = 1'b0;
        first_done = 0;
        for (int k = 1; k <= RND; k++) begin
            @(negedge clk);
            if (ifa.done && first_done == 0) first_done = k;
        end
    endtask

    initial begin : main
        vec_t vecs[4];
        int   fd;
        blk_t q[$];
        blk_t exp_d;

        vecs[0] = '{32'h00000000, 32'h00000000, 32'h22222222};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000000, 32'hAAAAAAAA};
        vecs[2] = '{32'h10101010, 32'h03030303, 32'h22222222};
        vecs[3] = '{32'h00000000, 32'h01000000, 32'hC9AD0420};

        rst_n = 1'b0; start = 1'b0; iv = '0; blk_data = '0; blk_valid = 1'b0; blk_last = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_d", ifa.d, 0);
        chk("rst_done", ifa.done, 0);
        chk("rst_busy", ifa.busy, 0);
        chk("rst_ready", ifa.blk_ready, 0);
        chk("rst_cnt", ifa.blk_count, 0);
        rst_n = 1'b1;

        // two zero blocks chained from a zero IV
        do_start(32'h0);
        absorb(32'h0, 1'b0, fd);
        chk("b1_no_done", fd, 0);
        chk("b1_d_held", ifa.d, 0);
        chk("b1_chain", dut.h, 32'h22222222);
        chk("b1_busy", ifa.busy, 1);
        absorb(32'h0, 1'b1, fd);
        chk("b2_latency", fd, RND);
        chk("b2_d", ifa.d, 32'h22222222);
        chk("b2_cnt", ifa.blk_count, 2);

        foreach (vecs[v]) begin
            do_start(vecs[v].iv);
            absorb(vecs[v].blk, 1'b1, fd);
            chk($sformatf("vec%0d_latency", v), fd, RND);
            chk($sformatf("vec%0d_d", v), ifa.d, vecs[v].exp);
            chk($sformatf("vec%0d_d_cnt2", v), ifb.d, vecs[v].exp);
            chk($sformatf("vec%0d_cnt", v), ifa.blk_count, 1);
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", v), ifa.done, 0);
            chk($sformatf("vec%0d_busy_after", v), ifa.busy, 0);
        end

        // valid held high throughout, data scribbled during rounds
        begin : handshake
            int acc;
            int rdy;
            bit got_done;
            bit scribbled;
            q = {32'h01020304, 32'h05060708};
            exp_d = model_msg(32'h34550F14, q);
            @(negedge clk);
            chk("hs_idle_ready", ifa.blk_ready, 0);
            start = 1'b1; iv = 32'h34550F14;
            blk_valid = 1'b1; blk_data = 32'h01020304; blk_last = 1'b0;
            @(negedge clk);
            start = 1'b0;
            acc = 0; rdy = 0; got_done = 0; scribbled = 0;
            for (int cyc = 0; cyc < 40 && !got_done; cyc++) begin
                if (ifa.done) begin
                    got_done = 1;
                end else begin
                    if (ifa.blk_ready) begin
                        rdy++;
                        if (blk_valid) acc++;
                    end else if (acc == 1) begin
                        if (!scribbled) begin
                            blk_data  = 32'hDEADBEEF;
                            scribbled = 1;
                        end else begin
                            blk_data = 32'h05060708;
                            blk_last = 1'b1;
                        end
                    end else if (acc == 2) begin
                        blk_data = 32'hCAFEF00D;
                        blk_last = 1'b0;
                    end
                    @(negedge clk);
                end
            end
            blk_valid = 1'b0;
            chk("hs_done_seen", got_done, 1);
            chk("hs_accepts", acc, 2);
            chk("hs_ready_cycles", rdy, 2);
            chk("hs_d", ifa.d, exp_d);
            @(negedge clk);
            chk("hs_done_pulse", ifa.done, 0);
        end

        // start during ROUND must be ignored
        begin : ignore_start
            int n;
            q = {32'h11223344};
            exp_d = model_msg(32'h34550F14, q);
            do_start(32'h34550F14);
            blk_data = 32'h11223344; blk_last = 1'b1; blk_valid = 1'b1;
            n = 0;
            while (!ifa.blk_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            blk_valid = 1'b0;
            start = 1'b1; iv = 32'hBBAA9988;
            repeat (2) @(negedge clk);
            start = 1'b0;
            n = 0;
            while (!ifa.done && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("ign_done_seen", ifa.done, 1);
            chk("ign_d", ifa.d, exp_d);
            chk("ign_cnt", ifa.blk_count, 1);
            @(negedge clk);
            chk("ign_busy_after", ifa.busy, 0);
        end

        // reset in the middle of a block aborts the message
        begin : mid_reset
            int n;
            int dn;
            do_start(32'h01020304);
            blk_data = 32'h0A0B0C0D; blk_last = 1'b1; blk_valid = 1'b1;
            n = 0;
            while (!ifa.blk_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            @(negedge clk);
            blk_valid = 1'b0;
            @(negedge clk);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk("mr_d", ifa.d, 0);
            chk("mr_done", ifa.done, 0);
            chk("mr_busy", ifa.busy, 0);
            chk("mr_ready", ifa.blk_ready, 0);
            chk("mr_cnt", ifa.blk_count, 0);
            dn = 0;
            repeat (6) begin
                @(negedge clk);
                if (ifa.done) dn++;
            end
            chk("mr_no_done", dn, 0);
            q = {32'h12345678};
            exp_d = model_msg(32'hA5A5A5A5, q);
            do_start(32'hA5A5A5A5);
            absorb(32'h12345678, 1'b1, fd);
            chk("mr_fresh_latency", fd, RND);
            chk("mr_fresh_d", ifa.d, exp_d);
        end

        // six-block message: 8-bit counter counts, 2-bit counter saturates
        q = {32'h00000001, 32'h00000200, 32'h00030000, 32'h04000000, 32'hF0E0D0C0, 32'h13579BDF};
        exp_d = model_msg(32'h0F1E2D3C, q);
        do_start(32'h0F1E2D3C);
        for (int k = 0; k < 6; k++) begin
            absorb(q[k], k == 5, fd);
            chk($sformatf("six_cnt8_%0d", k), ifa.blk_count, k + 1);
            chk($sformatf("six_cnt2_%0d", k), ifb.blk_count, (k < 3) ? k + 1 : 3);
        end
        chk("six_latency", fd, RND);
        chk("six_d", ifa.d, exp_d);
        chk("six_d_cnt2", ifb.d, exp_d);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
